// File: rtl/csi2tx_raw6_pixel_capture_if.sv
// Sensor-side parallel pixel bus carrying the frame/line qualifiers and the RAW6 pixel.
// The sensor (or its model) is the master and the capture block is the slave.
interface csi2tx_raw6_pixel_capture_if;
  logic       sensor_frame_vld;
  logic       sensor_line_vld;
  logic       sensor_pixel_vld;
  logic [5:0] sensor_pixel_data;

  modport master (
    output sensor_frame_vld,
    output sensor_line_vld,
    output sensor_pixel_vld,
    output sensor_pixel_data
  );

  modport slave (
    input sensor_frame_vld,
    input sensor_line_vld,
    input sensor_pixel_vld,
    input sensor_pixel_data
  );
endinterface

// File: rtl/csi2tx_raw6_pixel_capture.sv
// RAW6 capture front end: registers sensor pixels for the dword packer, marks end of line,
// and reports per-line pixel and byte counts plus a sticky line-length error.
module csi2tx_raw6_pixel_capture #(
  parameter int LINE_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  csi2tx_raw6_pixel_capture_if.slave sensor,
  input  logic                  raw6_convrn_enable,
  input  logic [LINE_CNT_W-1:0] exp_line_pixels,
  output logic [5:0]            pixel_data,
  output logic [5:0]            pixel_data_d1,
  output logic                  pixel_data_vld,
  output logic [3:0]            pixel_cnt,
  output logic                  sensor_pixel_vld_falling_edge,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic                  line_info_vld,
  output logic [LINE_CNT_W-1:0] line_pixel_total,
  output logic [LINE_CNT_W:0]   line_byte_cnt,
  output logic                  line_len_err
);

  typedef enum logic [1:0] {IDLE, FRAME, LINE, LINE_END} state_t;

  localparam logic [LINE_CNT_W+1:0] THREE = 3;

  state_t                  state_reg;
  logic [LINE_CNT_W-1:0]   line_cnt_reg;
  // Resets high so a frame already in progress at reset release is skipped.
  logic                    frame_vld_prev_reg;
  logic                    accept;
  logic                    line_done;
  logic [LINE_CNT_W+1:0]   byte_calc;

  assign accept = (state_reg == FRAME || state_reg == LINE) && sensor.sensor_frame_vld &&
                  sensor.sensor_line_vld && sensor.sensor_pixel_vld;
  assign line_done = !sensor.sensor_line_vld || !sensor.sensor_frame_vld;
  // ceil(count * 6 / 8) == (count * 3 + 3) >> 2
  assign byte_calc = ({2'b00, line_cnt_reg} * THREE + THREE) >> 2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg                     <= IDLE;
      line_cnt_reg                  <= '0;
      frame_vld_prev_reg            <= 1'b1;
      pixel_data                    <= '0;
      pixel_data_d1                 <= '0;
      pixel_data_vld                <= 1'b0;
      pixel_cnt                     <= '0;
      sensor_pixel_vld_falling_edge <= 1'b0;
      frame_start                   <= 1'b0;
      frame_end                     <= 1'b0;
      line_info_vld                 <= 1'b0;
      line_pixel_total              <= '0;
      line_byte_cnt                 <= '0;
      line_len_err                  <= 1'b0;
    end else begin
      frame_vld_prev_reg            <= sensor.sensor_frame_vld;
      sensor_pixel_vld_falling_edge <= 1'b0;
      frame_start                   <= 1'b0;
      frame_end                     <= 1'b0;
      line_info_vld                 <= 1'b0;
      pixel_data_vld                <= accept;
      if (!raw6_convrn_enable) begin
        state_reg        <= IDLE;
        line_cnt_reg     <= '0;
        pixel_data       <= '0;
        pixel_data_d1    <= '0;
        pixel_data_vld   <= 1'b0;
        pixel_cnt        <= '0;
        line_pixel_total <= '0;
        line_byte_cnt    <= '0;
        line_len_err     <= 1'b0;
      end else begin
        if (pixel_data_vld) pixel_cnt <= pixel_cnt + 4'd1;
        if (accept) begin
          pixel_data    <= sensor.sensor_pixel_data;
          pixel_data_d1 <= pixel_data;
          if (line_cnt_reg != '1) line_cnt_reg <= line_cnt_reg + 1'b1;
        end
        case (state_reg)
          IDLE: begin
            if (sensor.sensor_frame_vld && !frame_vld_prev_reg) begin
              state_reg    <= FRAME;
              frame_start  <= 1'b1;
              line_len_err <= 1'b0;
            end
          end
          FRAME: begin
            if (!sensor.sensor_frame_vld) begin
              state_reg <= IDLE;
              frame_end <= 1'b1;
            end else if (sensor.sensor_line_vld) begin
              state_reg <= LINE;
            end
          end
          LINE: begin
            if (line_done) begin
              state_reg                     <= LINE_END;
              sensor_pixel_vld_falling_edge <= 1'b1;
              pixel_data                    <= '0;
              line_pixel_total              <= line_cnt_reg;
              line_byte_cnt                 <= byte_calc[LINE_CNT_W:0];
              line_info_vld                 <= 1'b1;
              line_cnt_reg                  <= '0;
              if (line_cnt_reg != exp_line_pixels || line_cnt_reg[1:0] != 2'b00 ||
                  !sensor.sensor_frame_vld)
                line_len_err <= 1'b1;
            end
          end
          LINE_END: begin
            pixel_cnt <= '0;
            if (sensor.sensor_frame_vld) begin
              state_reg <= FRAME;
            end else begin
              state_reg <= IDLE;
              frame_end <= 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csi2tx_raw6_pixel_capture.sv
// Self-checking bench for the RAW6 capture front end: randomized lines against a
// per-line reference model of pixel stream, counts and error flag.
module tb_csi2tx_raw6_pixel_capture;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         raw6_convrn_enable = 1'b0;
  logic [W-1:0] exp_line_pixels = '0;
  logic [5:0]   pixel_data;
  logic [5:0]   pixel_data_d1;
  logic         pixel_data_vld;
  logic [3:0]   pixel_cnt;
  logic         sensor_pixel_vld_falling_edge;
  logic         frame_start;
  logic         frame_end;
  logic         line_info_vld;
  logic [W-1:0] line_pixel_total;
  logic [W:0]   line_byte_cnt;
  logic         line_len_err;

  int checks = 0;
  int errors = 0;
  bit err_model = 1'b0;

  csi2tx_raw6_pixel_capture_if sif ();

  csi2tx_raw6_pixel_capture #(.LINE_CNT_W(W)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .sensor                        (sif),
    .raw6_convrn_enable            (raw6_convrn_enable),
    .exp_line_pixels               (exp_line_pixels),
    .pixel_data                    (pixel_data),
    .pixel_data_d1                 (pixel_data_d1),
    .pixel_data_vld                (pixel_data_vld),
    .pixel_cnt                     (pixel_cnt),
    .sensor_pixel_vld_falling_edge (sensor_pixel_vld_falling_edge),
    .frame_start                   (frame_start),
    .frame_end                     (frame_end),
    .line_info_vld                 (line_info_vld),
    .line_pixel_total              (line_pixel_total),
    .line_byte_cnt                 (line_byte_cnt),
    .line_len_err                  (line_len_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] all_outs();
    return {pixel_data, pixel_data_d1, pixel_data_vld, pixel_cnt, sensor_pixel_vld_falling_edge,
            frame_start, frame_end, line_info_vld, line_pixel_total, line_byte_cnt, line_len_err};
  endfunction

  task automatic test_reset();
    sif.sensor_frame_vld = 0; sif.sensor_line_vld = 0;
    sif.sensor_pixel_vld = 0; sif.sensor_pixel_data = 0;
    rst = 1; raw6_convrn_enable = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs() !== 64'd0) begin
      errors++; $display("FAIL reset_outs got=%h exp=0", all_outs());
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if (all_outs() !== 64'd0) begin
      errors++; $display("FAIL reset_release_outs got=%h exp=0", all_outs());
    end
    $display("test_reset done");
  endtask

  task automatic start_frame();
    sif.sensor_frame_vld = 0; sif.sensor_line_vld = 0; sif.sensor_pixel_vld = 0;
    repeat (2) @(negedge clk);
    sif.sensor_frame_vld = 1;
    @(negedge clk);
    err_model = 1'b0;
    checks++;
    if (frame_start !== 1'b1) begin
      errors++; $display("FAIL frame_start got=%b exp=1", frame_start);
    end
    checks++;
    if (line_len_err !== 1'b0) begin
      errors++; $display("FAIL err_clear_on_start got=%b exp=0", line_len_err);
    end
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b0) begin
      errors++; $display("FAIL frame_start_pulse got=%b exp=0", frame_start);
    end
  endtask

  task automatic end_frame();
    sif.sensor_frame_vld = 0; sif.sensor_line_vld = 0; sif.sensor_pixel_vld = 0;
    @(negedge clk);
    checks++;
    if (frame_end !== 1'b1) begin
      errors++; $display("FAIL frame_end got=%b exp=1", frame_end);
    end
    @(negedge clk);
    checks++;
    if (frame_end !== 1'b0) begin
      errors++; $display("FAIL frame_end_pulse got=%b exp=0", frame_end);
    end
  endtask

  // gap_mode: 0 none, 1 gaps of 1 and 3 cycles, 2 random gaps. drop_at>=0 ends the line by
  // dropping frame_vld after that many pixels.
  task automatic run_line(input int n, input int exp_n, input int gap_mode, input int drop_at);
    bit         sched[$];
    logic [5:0] last = 6'd0;
    logic [5:0] cur;
    int         acc = 0;
    int         npix;
    bit         drop;
    drop = (drop_at >= 0);
    npix = drop ? drop_at : n;
    for (int p = 0; p < npix; p++) begin
      sched.push_back(1'b1);
      if (gap_mode == 1 && p == 3) sched.push_back(1'b0);
      if (gap_mode == 1 && p == 9) repeat (3) sched.push_back(1'b0);
      if (gap_mode == 2) repeat ($urandom_range(0, 2)) sched.push_back(1'b0);
    end
    exp_line_pixels = W'(exp_n);
    foreach (sched[i]) begin
      cur = 6'($urandom);
      sif.sensor_line_vld = 1; sif.sensor_pixel_vld = sched[i]; sif.sensor_pixel_data = cur;
      @(negedge clk);
      if (sched[i]) begin
        acc++;
        checks++;
        if (pixel_data_vld !== 1'b1 || pixel_data !== cur) begin
          errors++; $display("FAIL pix_beat%0d got vld=%b data=%h exp vld=1 data=%h", acc - 1, pixel_data_vld, pixel_data, cur);
        end
        checks++;
        if (pixel_cnt !== 4'((acc - 1) % 16) || pixel_data_d1 !== last) begin
          errors++; $display("FAIL pix_idx%0d got cnt=%0d d1=%h exp cnt=%0d d1=%h", acc - 1, pixel_cnt, pixel_data_d1, (acc - 1) % 16, last);
        end
        last = cur;
      end else begin
        checks++;
        if (pixel_data_vld !== 1'b0 || pixel_data !== last || pixel_cnt !== 4'(acc % 16)) begin
          errors++; $display("FAIL gap got vld=%b data=%h cnt=%0d exp vld=0 data=%h cnt=%0d", pixel_data_vld, pixel_data, pixel_cnt, last, acc % 16);
        end
      end
    end
    if (drop) begin
      sif.sensor_frame_vld = 0; sif.sensor_line_vld = 1; sif.sensor_pixel_vld = 1;
      sif.sensor_pixel_data = 6'($urandom);
    end else begin
      sif.sensor_line_vld = 0; sif.sensor_pixel_vld = 0;
    end
    @(negedge clk);
    err_model = err_model | (npix != exp_n) | (npix % 4 != 0) | drop;
    checks++;
    if (sensor_pixel_vld_falling_edge !== 1'b1 || pixel_data_vld !== 1'b0 || pixel_data !== 6'd0 || pixel_cnt !== 4'(npix % 16)) begin
      errors++; $display("FAIL line_end_strobe got fe=%b vld=%b data=%h cnt=%0d exp fe=1 vld=0 data=0 cnt=%0d", sensor_pixel_vld_falling_edge, pixel_data_vld, pixel_data, pixel_cnt, npix % 16);
    end
    checks++;
    if (line_info_vld !== 1'b1 || line_pixel_total !== W'(npix) || line_byte_cnt !== (W + 1)'((6 * npix + 7) / 8)) begin
      errors++; $display("FAIL line_info got vld=%b total=%0d bytes=%0d exp vld=1 total=%0d bytes=%0d", line_info_vld, line_pixel_total, line_byte_cnt, npix, (6 * npix + 7) / 8);
    end
    checks++;
    if (line_len_err !== err_model || frame_end !== 1'b0) begin
      errors++; $display("FAIL line_err got err=%b fend=%b exp err=%b fend=0", line_len_err, frame_end, err_model);
    end
    sif.sensor_line_vld = 0; sif.sensor_pixel_vld = 0;
    @(negedge clk);
    checks++;
    if (sensor_pixel_vld_falling_edge !== 1'b0 || line_info_vld !== 1'b0 || pixel_cnt !== 4'd0 || line_len_err !== err_model || frame_end !== drop) begin
      errors++; $display("FAIL after_line got fe=%b info=%b cnt=%0d err=%b fend=%b exp fe=0 info=0 cnt=0 err=%b fend=%b", sensor_pixel_vld_falling_edge, line_info_vld, pixel_cnt, line_len_err, frame_end, err_model, drop);
    end
    $display("line n=%0d exp=%0d gaps=%0d drop=%0d err=%b", npix, exp_n, gap_mode, drop, err_model);
  endtask

  task automatic test_two_lines();
    start_frame();
    run_line(16, 16, 0, -1);
    run_line(16, 16, 0, -1);
    end_frame();
  endtask

  task automatic test_short_line();
    start_frame();
    run_line(12, 12, 0, -1);
    end_frame();
  endtask

  task automatic test_gaps();
    start_frame();
    run_line(16, 16, 1, -1);
    end_frame();
  endtask

  task automatic test_len_err();
    start_frame();
    run_line(10, 12, 0, -1);
    run_line(8, 8, 0, -1);
    end_frame();
    start_frame();
    run_line(4, 4, 0, -1);
    end_frame();
  endtask

  task automatic test_frame_drop();
    start_frame();
    run_line(16, 16, 0, 7);
  endtask

  task automatic test_random_lines();
    int n;
    int e;
    for (int f = 0; f < 4; f++) begin
      start_frame();
      for (int l = 0; l < int'($urandom_range(1, 3)); l++) begin
        n = $urandom_range(1, 40);
        e = ($urandom_range(0, 1) == 1) ? n : $urandom_range(1, 40);
        run_line(n, e, 2, -1);
      end
      end_frame();
    end
  endtask

  // Abort a line at pixel 5 either by async reset (use_rst=1) or by dropping the enable.
  task automatic test_abort_mid_line(input bit use_rst);
    start_frame();
    for (int i = 0; i < 5; i++) begin
      sif.sensor_line_vld = 1; sif.sensor_pixel_vld = 1; sif.sensor_pixel_data = 6'($urandom);
      @(negedge clk);
    end
    sif.sensor_pixel_data = 6'($urandom);
    if (use_rst) begin
      #1 rst = 1;
      #1;
      checks++;
      if (all_outs() !== 64'd0) begin
        errors++; $display("FAIL async_rst_outs got=%h exp=0", all_outs());
      end
      @(negedge clk);
      rst = 0;
    end else begin
      raw6_convrn_enable = 0;
      @(negedge clk);
      checks++;
      if (all_outs() !== 64'd0) begin
        errors++; $display("FAIL enable_low_outs got=%h exp=0", all_outs());
      end
      raw6_convrn_enable = 1;
    end
    err_model = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sif.sensor_pixel_data = 6'($urandom);
      @(negedge clk);
      checks++;
      if (pixel_data_vld !== 1'b0 || sensor_pixel_vld_falling_edge !== 1'b0 || frame_start !== 1'b0 || pixel_cnt !== 4'd0) begin
        errors++; $display("FAIL ignored_after_abort got vld=%b fe=%b fs=%b cnt=%0d exp all 0", pixel_data_vld, sensor_pixel_vld_falling_edge, frame_start, pixel_cnt);
      end
    end
    start_frame();
    run_line(4, 4, 0, -1);
    end_frame();
    $display("abort mid line use_rst=%b done", use_rst);
  endtask

  initial begin
    test_reset();
    test_two_lines();
    test_short_line();
    test_gaps();
    test_len_err();
    test_frame_drop();
    test_random_lines();
    test_abort_mid_line(1'b1);
    test_abort_mid_line(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csi2tx_raw6_pixel_capture.md
Name: csi2tx_raw6_pixel_capture

Overview:
Sensor-side front end for the RAW6 pixel-to-byte path.
- Samples the parallel sensor bus, qualified by frame and line valid.
- Presents registered pixels with a mod-16 pixel index, the previous pixel, and a one-cycle end-of-line strobe. These are the exact inputs the RAW6 dword packer consumes.
- Tracks line length and frame/line boundaries, and reports per-line pixel and byte counts for packet-header word-count generation.

Parameters:
LINE_CNT_W, 16, width of the per-line pixel counter and the expected-length input.

Ports:
clk  input  1  pixel clock
rst  input  1  asynchronous reset, active-high
raw6_convrn_enable  input  1  RAW6 path enable; low forces IDLE and clears all state
sensor_frame_vld  input  1  frame valid from sensor
sensor_line_vld  input  1  line valid from sensor
sensor_pixel_vld  input  1  pixel strobe; ignored unless sensor_line_vld=1
sensor_pixel_data  input  6  RAW6 pixel
exp_line_pixels  input  LINE_CNT_W  expected pixels per line (programmed)
pixel_data  output  6  registered pixel
pixel_data_d1  output  6  previously presented valid pixel
pixel_data_vld  output  1  pixel_data holds a new pixel this cycle
pixel_cnt  output  4  index mod 16 of the pixel on pixel_data
sensor_pixel_vld_falling_edge  output  1  one-cycle end-of-line strobe
frame_start  output  1  one-cycle pulse on frame start
frame_end  output  1  one-cycle pulse on frame end
line_info_vld  output  1  one-cycle pulse; line_pixel_total/line_byte_cnt valid
line_pixel_total  output  LINE_CNT_W  pixels received in the last line
line_byte_cnt  output  LINE_CNT_W+1  ceil(line_pixel_total*6/8)
line_len_err  output  1  sticky error; cleared on frame_start

Behaviour:
- All outputs are registered. Reset value of every output is 0. Internal state resets to IDLE.
- State machine (states IDLE, FRAME, LINE, LINE_END):
  - IDLE→FRAME on sensor_frame_vld=1; frame_start pulses the next cycle and line_len_err clears.
  - FRAME→LINE on sensor_line_vld=1. That same cycle's pixel is accepted if sensor_pixel_vld=1.
  - FRAME→IDLE on sensor_frame_vld=0; frame_end pulses.
  - LINE→LINE_END on sensor_line_vld=0 or sensor_frame_vld=0.
  - LINE_END lasts one cycle. It returns to FRAME if sensor_frame_vld=1, else goes to IDLE with a frame_end pulse.
- Pixel path latency is 1 cycle. A pixel accepted at cycle t (state LINE, or the FRAME→LINE cycle, with line_vld=1 and pixel_vld=1) gives pixel_data=sensor_pixel_data and pixel_data_vld=1 at t+1.
- pixel_data holds its value when no pixel is accepted.
- pixel_data_d1 loads the old pixel_data on every accepted pixel, so while pixel k is presented, d1 holds pixel k-1.
- pixel_cnt equals the index of the pixel on pixel_data. It increments by 1 (mod 16, 15→0 wrap) in the cycle after each pixel_data_vld=1.
- Gaps in sensor_pixel_vld within a line: pixel_cnt and pixel_data hold.
- In the LINE_END cycle:
  - sensor_pixel_vld_falling_edge=1.
  - pixel_data_vld=0.
  - pixel_cnt holds (number of pixels mod 16), so a nonzero value signals a partial dword downstream.
  - pixel_data is driven to 0 so padding bits are zero.
  - pixel_cnt clears to 0 on the following cycle.
- Line counter: LINE_CNT_W bits, counts accepted pixels, saturates at all-ones. At LINE_END it is copied to line_pixel_total and line_byte_cnt = (count*3+3)>>2, line_info_vld pulses, and the counter clears.
- line_len_err is set at LINE_END if any of these hold:
  - count != exp_line_pixels;
  - count[1:0] != 0 (RAW6 lines must be a multiple of 4 pixels);
  - the line was terminated by sensor_frame_vld falling.
- line_vld rising in LINE_END is not a new line. The controller must return to FRAME first, which enforces a minimum 1-cycle line blank.
- Pixels arriving in IDLE, LINE_END, or with line_vld=0 are dropped and not counted.
- raw6_convrn_enable=0 for any cycle, checked synchronously ahead of all other transitions:
  - state goes to IDLE;
  - counters, pixel_cnt and pixel_data clear;
  - no strobes are issued.
- rst asserted mid-line: all outputs go to 0 immediately and asynchronously. After deassert, capture resumes only from the next frame_vld rising into IDLE→FRAME.
- exp_line_pixels is sampled only at LINE_END.

Test Plan:
1. Frame of two 16-pixel lines, data 0..15, exp=16 → pixel_cnt 0..15 aligned with pixel_data_vld; d1=k-1; falling_edge with pixel_cnt=0; line_pixel_total=16, line_byte_cnt=12; no error; frame_start/frame_end once each.
2. 12-pixel line, exp=12 → falling_edge with pixel_cnt=12 and pixel_data=0; line_byte_cnt=9; pixel_cnt=0 the next cycle.
3. 16-pixel line with sensor_pixel_vld gaps of 1 and 3 cycles → pixel_cnt/pixel_data hold across gaps; 16 valid beats total; line_pixel_total=16.
4. 10-pixel line, exp=12 → line_pixel_total=10, line_byte_cnt=8, line_len_err=1 and sticky; it clears at the next frame_start.
5. frame_vld drops at pixel 7 of a line → LINE_END strobe with pixel_cnt=7, line_len_err=1, frame_end pulse, return to IDLE.
6. rst pulse at pixel 5, and separately raw6_convrn_enable low at pixel 5 → all outputs 0 and no falling_edge strobe; pixels are ignored until a new frame_vld rising edge, after which pixel_cnt restarts at 0.
